// File: rtl/ps2_host_tx_if.sv
// Command handshake between a host controller and the PS/2 host transmitter.
// The controller side uses the master modport; the transmitter uses slave.
interface ps2_host_tx_if;
  logic [7:0] data_in;
  logic       R_I;
  logic       busy;
  logic       R_O;
  logic       ack_error;

  modport master (output data_in, output R_I, input busy, input R_O, input ack_error);
  modport slave  (input data_in, input R_I, output busy, output R_O, output ack_error);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends one command frame
// clocked by the device, checks the device ack and reports completion.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic         clk,
  input  logic         reset,
  ps2_host_tx_if.slave host,
  input  logic         PS2_clk,
  input  logic         PS2_dat,
  output logic         PS2_clk_low,
  output logic         PS2_dat_low
);
  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_START     = 3'd2,
    S_SEND      = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t           state_r, state_s;
  logic [8:0]       shift_r, shift_s;
  logic [INH_W-1:0] inh_cnt_r, inh_cnt_s;
  logic [TMO_W-1:0] tmo_cnt_r, tmo_cnt_s;
  logic [3:0]       edge_cnt_r, edge_cnt_s;
  logic             busy_r, busy_s;
  logic             r_o_r, r_o_s;
  logic             ack_error_r, ack_error_s;
  logic             clk_low_r, clk_low_s;
  logic             dat_low_r, dat_low_s;
  logic             clk_meta_r, clk_sync_r, clk_prev_r;
  logic             dat_meta_r, dat_sync_r;
  logic             fe_s;
  logic             tmo_hit_s;

  assign fe_s = clk_prev_r & ~clk_sync_r;
  assign tmo_hit_s = (tmo_cnt_r == TMO_LAST);

  assign host.busy      = busy_r;
  assign host.R_O       = r_o_r;
  assign host.ack_error = ack_error_r;
  assign PS2_clk_low    = clk_low_r;
  assign PS2_dat_low    = dat_low_r;

  // Pin synchronizers and falling-edge history, idle-bus value is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_meta_r <= 1'b1;
      clk_sync_r <= 1'b1;
      clk_prev_r <= 1'b1;
      dat_meta_r <= 1'b1;
      dat_sync_r <= 1'b1;
    end else begin
      clk_meta_r <= PS2_clk;
      clk_sync_r <= clk_meta_r;
      clk_prev_r <= clk_sync_r;
      dat_meta_r <= PS2_dat;
      dat_sync_r <= dat_meta_r;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      shift_r     <= 9'd0;
      inh_cnt_r   <= '0;
      tmo_cnt_r   <= '0;
      edge_cnt_r  <= 4'd0;
      busy_r      <= 1'b0;
      r_o_r       <= 1'b0;
      ack_error_r <= 1'b0;
      clk_low_r   <= 1'b0;
      dat_low_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      shift_r     <= shift_s;
      inh_cnt_r   <= inh_cnt_s;
      tmo_cnt_r   <= tmo_cnt_s;
      edge_cnt_r  <= edge_cnt_s;
      busy_r      <= busy_s;
      r_o_r       <= r_o_s;
      ack_error_r <= ack_error_s;
      clk_low_r   <= clk_low_s;
      dat_low_r   <= dat_low_s;
    end
  end

  // Next-state and next-output logic; line controls are computed one cycle ahead.
  always_comb begin
    state_s     = state_r;
    shift_s     = shift_r;
    inh_cnt_s   = inh_cnt_r;
    tmo_cnt_s   = tmo_cnt_r;
    edge_cnt_s  = edge_cnt_r;
    busy_s      = busy_r;
    r_o_s       = 1'b0;
    ack_error_s = ack_error_r;
    clk_low_s   = clk_low_r;
    dat_low_s   = dat_low_r;
    case (state_r)
      S_IDLE: begin
        if (host.R_I) begin
          shift_s     = {odd_parity(host.data_in), host.data_in};
          ack_error_s = 1'b0;
          busy_s      = 1'b1;
          inh_cnt_s   = '0;
          clk_low_s   = 1'b1;
          dat_low_s   = (INH_LAST == '0);
          state_s     = S_INHIBIT;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_INHIBIT: begin
        // Data is pulled low during the final inhibit cycle so the start bit is already set up.
        if (inh_cnt_r == INH_LAST) begin
          clk_low_s = 1'b0;
          dat_low_s = 1'b1;
          tmo_cnt_s = '0;
          state_s   = S_START;
        end else begin
          inh_cnt_s = inh_cnt_r + INH_W'(1);
          dat_low_s = (inh_cnt_s == INH_LAST);
        end
      end
      S_START, S_SEND, S_ACK, S_WAIT_IDLE: begin
        if (tmo_hit_s) begin
          clk_low_s   = 1'b0;
          dat_low_s   = 1'b0;
          ack_error_s = 1'b1;
          busy_s      = 1'b0;
          r_o_s       = 1'b1;
          state_s     = S_DONE;
        end else begin
          tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
          case (state_r)
            S_START: begin
              if (fe_s) begin
                dat_low_s  = ~shift_r[0];
                shift_s    = {1'b0, shift_r[8:1]};
                edge_cnt_s = 4'd1;
                state_s    = S_SEND;
              end else begin
                state_s = S_START;
              end
            end
            S_SEND: begin
              // Edges 2..9 shift out d1..d7 and parity; edge 10 releases data for the stop bit.
              if (fe_s && (edge_cnt_r == 4'd9)) begin
                dat_low_s  = 1'b0;
                edge_cnt_s = 4'd10;
                state_s    = S_ACK;
              end else if (fe_s) begin
                dat_low_s  = ~shift_r[0];
                shift_s    = {1'b0, shift_r[8:1]};
                edge_cnt_s = edge_cnt_r + 4'd1;
              end else begin
                state_s = S_SEND;
              end
            end
            S_ACK: begin
              if (fe_s) begin
                ack_error_s = dat_sync_r;
                edge_cnt_s  = 4'd11;
                state_s     = S_WAIT_IDLE;
              end else begin
                state_s = S_ACK;
              end
            end
            S_WAIT_IDLE: begin
              if (clk_sync_r && dat_sync_r) begin
                busy_s  = 1'b0;
                r_o_s   = 1'b1;
                state_s = S_DONE;
              end else begin
                state_s = S_WAIT_IDLE;
              end
            end
            default: begin
              state_s = S_IDLE;
            end
          endcase
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        clk_low_s = 1'b0;
        dat_low_s = 1'b0;
        busy_s    = 1'b0;
        state_s   = S_IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-drain PS/2 device model
// that clocks frames, captures the bits and optionally acks.
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int TMO = 5000;

  logic clk;
  logic reset;
  logic PS2_clk_low, PS2_dat_low;
  logic ps2_clk_pin, ps2_dat_pin;
  logic dev_clk_low, dev_dat_low;
  int   dev_mode;
  int   dev_fe;
  logic dev_active;
  logic cap_valid;
  logic [10:0] cap;
  int   ro_count;
  int   total_cnt;
  int   pass_cnt;

  ps2_host_tx_if host ();

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .host        (host.slave),
    .PS2_clk     (ps2_clk_pin),
    .PS2_dat     (ps2_dat_pin),
    .PS2_clk_low (PS2_clk_low),
    .PS2_dat_low (PS2_dat_low)
  );

  assign ps2_clk_pin = ~(PS2_clk_low | dev_clk_low);
  assign ps2_dat_pin = ~(PS2_dat_low | dev_dat_low);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (host.R_O === 1'b1) ro_count <= ro_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected frame bits as seen by the device: start, d0..d7, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    f = 11'd0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = ((d >> i) & 8'd1) != 8'd0;
      ones += int'((d >> i) & 8'd1);
    end
    f[9] = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Device model: mode 0 acks, mode 1 never acks, mode 2 never clocks.
  initial begin
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    dev_active  = 1'b0;
    cap_valid   = 1'b0;
    cap         = 11'd0;
    dev_fe      = 0;
    forever begin
      @(negedge clk);
      if (ps2_clk_pin === 1'b1 && ps2_dat_pin === 1'b0 && reset === 1'b1) begin
        dev_active = 1'b1;
        cap_valid  = 1'b0;
        cap        = 11'h7ff;
        dev_fe     = 0;
        repeat (25) @(negedge clk);
        cap[0] = ps2_dat_pin;
        if (dev_mode == 2) begin
          for (int w = 0; w < 10000 && PS2_dat_low === 1'b1; w++) @(negedge clk);
        end else begin
          repeat (25) @(negedge clk);
          for (int k = 1; k <= 11; k++) begin
            dev_clk_low = 1'b1;
            dev_fe = k;
            repeat (50) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (25) @(negedge clk);
            if (k <= 10) cap[k] = ps2_dat_pin;
            if (k == 10 && dev_mode == 0) dev_dat_low = 1'b1;
            if (k == 11) dev_dat_low = 1'b0;
            repeat (25) @(negedge clk);
          end
          cap_valid = 1'b1;
        end
        dev_active = 1'b0;
      end
    end
  end

  task automatic wait_dev_idle(input string tag);
    int w;
    w = 0;
    while (dev_active === 1'b1 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_dev_done"}, 32'(w < 3000), 32'd1);
  endtask

  task automatic do_xfer(input logic [7:0] d, input int mode, input bit extra, input string tag);
    int cnt;
    int w;
    int ro_before;
    logic d_prev, d_last, busy_prev;
    dev_mode = mode;
    ro_before = ro_count;
    @(negedge clk);
    host.data_in = d;
    host.R_I = 1'b1;
    @(negedge clk);
    host.R_I = 1'b0;
    host.data_in = ~d;
    cnt = 0;
    d_prev = 1'bx;
    d_last = 1'bx;
    while (PS2_clk_low === 1'b1 && cnt < 100) begin
      cnt++;
      d_prev = d_last;
      d_last = PS2_dat_low;
      @(negedge clk);
    end
    check({tag, "_inhibit_len"}, 32'(cnt), 32'(INH));
    check({tag, "_dat_low_last_inhibit"}, 32'(d_last), 32'd1);
    check({tag, "_dat_low_pre_last"}, 32'(d_prev), 32'd0);
    w = 0;
    busy_prev = 1'b0;
    while (host.R_O !== 1'b1 && w < 8000) begin
      busy_prev = host.busy;
      host.R_I = extra && (w % 300 == 5);
      @(negedge clk);
      w++;
    end
    host.R_I = 1'b0;
    check({tag, "_ro_seen"}, 32'(host.R_O), 32'd1);
    check({tag, "_busy_during"}, 32'(busy_prev), 32'd1);
    check({tag, "_busy_at_ro"}, 32'(host.busy), 32'd0);
    check({tag, "_ack_error"}, 32'(host.ack_error), 32'(mode != 0));
    check({tag, "_lines_released"}, 32'({PS2_clk_low, PS2_dat_low}), 32'd0);
    if (mode == 2) check({tag, "_timeout_cycles"}, 32'(w), 32'(TMO));
    wait_dev_idle(tag);
    if (mode != 2) check({tag, "_frame"}, 32'(cap), 32'(frame_of(d)));
    repeat (10) @(negedge clk);
    check({tag, "_ro_pulses"}, 32'(ro_count - ro_before), 32'd1);
    check({tag, "_ack_error_held"}, 32'(host.ack_error), 32'(mode != 0));
  endtask

  initial begin
    logic [7:0] rd;
    int w;
    int ro_before;
    total_cnt = 0;
    pass_cnt = 0;
    ro_count = 0;
    dev_mode = 0;
    reset = 1'b0;
    host.R_I = 1'b0;
    host.data_in = 8'h00;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(host.busy), 32'd0);
    check("reset_ro", 32'(host.R_O), 32'd0);
    check("reset_ack_error", 32'(host.ack_error), 32'd0);
    check("reset_clk_low", 32'(PS2_clk_low), 32'd0);
    check("reset_dat_low", 32'(PS2_dat_low), 32'd0);

    do_xfer(8'hED, 0, 1'b0, "ed");
    check("ed_parity_bit", 32'(cap[9]), 32'd1);
    do_xfer(8'h00, 0, 1'b0, "x00");
    check("x00_parity_bit", 32'(cap[9]), 32'd1);
    do_xfer(8'h01, 0, 1'b0, "x01");
    check("x01_parity_bit", 32'(cap[9]), 32'd0);
    for (int i = 0; i < 5; i++) begin
      rd = 8'($urandom_range(255, 0));
      do_xfer(rd, 0, 1'b0, "rand");
    end
    do_xfer(8'($urandom_range(255, 0)), 1, 1'b0, "noack");
    do_xfer(8'hFF, 2, 1'b0, "timeout");
    do_xfer(8'($urandom_range(255, 0)), 0, 1'b1, "extra_ri");

    // Reset in the middle of the frame, after data bit 3 has been driven.
    dev_mode = 1;
    ro_before = ro_count;
    @(negedge clk);
    host.data_in = 8'h00;
    host.R_I = 1'b1;
    @(negedge clk);
    host.R_I = 1'b0;
    w = 0;
    while (dev_fe != 4 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check("midreset_reached_bit4", 32'(w < 3000), 32'd1);
    repeat (10) @(negedge clk);
    check("midreset_dat_low_before", 32'(PS2_dat_low), 32'd1);
    reset = 1'b0;
    #1;
    check("midreset_lines", 32'({PS2_clk_low, PS2_dat_low}), 32'd0);
    check("midreset_busy", 32'(host.busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    wait_dev_idle("midreset");
    repeat (20) @(negedge clk);
    check("midreset_no_ro", 32'(ro_count - ro_before), 32'd0);
    check("midreset_idle_lines", 32'({PS2_clk_low, PS2_dat_low, host.busy}), 32'd0);
    do_xfer(8'($urandom_range(255, 0)), 0, 1'b0, "after_reset");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
